// File: rtl/circle_anim.sv
// Rotating perimeter "snake" across a row of 7-segment digits.
// Steps once per rising edge of tick_i; seg_o is a registered decode.
module circle_anim #(
   parameter int DIGITS = 4,
   parameter int LEN    = 3,
   parameter int POS_W  = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  tick_i,
   input  logic                  en_i,
   input  logic                  dir_i,
   input  logic                  clr_i,
   output logic [7*DIGITS-1:0]   seg_o,
   output logic                  wrap_o
);

   localparam int SEG_W = 7 * DIGITS;
   localparam int NPOS  = 2 * DIGITS + 4;
   localparam int LAST  = NPOS - 1;
   localparam logic [POS_W-1:0] LAST_P = POS_W'(LAST);

   logic             tick_q;
   logic             dir_q;
   logic             step;
   logic [POS_W-1:0] pos;
   logic [POS_W-1:0] pos_n;
   logic             wrap_n;
   logic [SEG_W-1:0] seg_n;

   assign step = tick_i & ~tick_q & en_i;

   // Perimeter position -> bit index in seg_o
   function automatic int seg_idx(input int p);
      int r;
      r = 0;
      if (p < DIGITS)
         r = 7 * (DIGITS - 1 - p);
      else if (p == DIGITS)
         r = 1;
      else if (p == DIGITS + 1)
         r = 2;
      else if (p <= 2 * DIGITS + 1)
         r = 7 * (p - DIGITS - 2) + 3;
      else if (p == 2 * DIGITS + 2)
         r = 7 * (DIGITS - 1) + 4;
      else
         r = 7 * (DIGITS - 1) + 5;
      return r;
   endfunction

   always_comb begin
      pos_n  = pos;
      wrap_n = 1'b0;
      if (dir_i) begin
         if (pos == '0) begin
            pos_n  = LAST_P;
            wrap_n = 1'b1;
         end else begin
            pos_n = pos - POS_W'(1);
         end
      end else begin
         if (pos == LAST_P) begin
            pos_n  = '0;
            wrap_n = 1'b1;
         end else begin
            pos_n = pos + POS_W'(1);
         end
      end
   end

   // Distance behind the head, measured against the travel direction
   always_comb begin
      int d;
      d     = 0;
      seg_n = '0;
      for (int p = 0; p < NPOS; p++) begin
         d = dir_q ? (p - int'(pos)) : (int'(pos) - p);
         if (d < 0)
            d = d + NPOS;
         if (d < LEN)
            seg_n = seg_n | (SEG_W'(1) << seg_idx(p));
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tick_q <= 1'b1;
         pos    <= '0;
         dir_q  <= 1'b0;
         wrap_o <= 1'b0;
         seg_o  <= '0;
      end else begin
         tick_q <= tick_i;
         seg_o  <= seg_n;
         if (clr_i) begin
            pos    <= '0;
            dir_q  <= 1'b0;
            wrap_o <= 1'b0;
         end else if (step) begin
            pos    <= pos_n;
            dir_q  <= dir_i;
            wrap_o <= wrap_n;
         end else begin
            wrap_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_circle_anim.sv
// Directed bench for circle_anim, DIGITS=4 LEN=3.
// Step table plus hand sequences for hold, enable, clear and reset.
module tb_circle_anim;

   logic        clk;
   logic        rst_n;
   logic        tick;
   logic        en;
   logic        dir;
   logic        clr;
   logic [27:0] seg;
   logic        wrap;

   int checks;
   int errors;
   int wraps;

   typedef struct {
      logic        dir;
      logic [27:0] seg;
      logic        wrap;
   } vec_t;

   vec_t tbl [16];

   circle_anim #(.DIGITS(4), .LEN(3), .POS_W(4)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .tick_i (tick),
      .en_i   (en),
      .dir_i  (dir),
      .clr_i  (clr),
      .seg_o  (seg),
      .wrap_o (wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [27:0] act,
                        input logic [27:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%07h expected 0x%07h", nm, act, exp);
      end
   endtask

   task automatic do_step(input string nm, input logic d,
                          input logic [27:0] es, input logic ew);
      @(negedge clk);
      tick = 1'b1;
      dir  = d;
      @(negedge clk);
      check({nm, ".wrap"}, 28'(wrap), 28'(ew));
      tick = 1'b0;
      @(negedge clk);
      check({nm, ".seg"}, seg, es);
      check({nm, ".wrap_end"}, 28'(wrap), 28'd0);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      wraps  = 0;

      tbl[0]  = '{1'b0, 28'h4204000, 1'b0};
      tbl[1]  = '{1'b0, 28'h0204080, 1'b0};
      tbl[2]  = '{1'b0, 28'h0004081, 1'b0};
      tbl[3]  = '{1'b0, 28'h0000083, 1'b0};
      tbl[4]  = '{1'b0, 28'h0000007, 1'b0};
      tbl[5]  = '{1'b0, 28'h000000E, 1'b0};
      tbl[6]  = '{1'b0, 28'h000040C, 1'b0};
      tbl[7]  = '{1'b0, 28'h0020408, 1'b0};
      tbl[8]  = '{1'b0, 28'h1020400, 1'b0};
      tbl[9]  = '{1'b0, 28'h3020000, 1'b0};
      tbl[10] = '{1'b0, 28'h7000000, 1'b0};
      tbl[11] = '{1'b0, 28'h6200000, 1'b1};
      tbl[12] = '{1'b1, 28'h4204000, 1'b1};
      tbl[13] = '{1'b1, 28'h6200000, 1'b0};
      tbl[14] = '{1'b1, 28'h7000000, 1'b0};
      tbl[15] = '{1'b0, 28'h3020000, 1'b0};

      rst_n = 1'b0;
      tick  = 1'b1;
      en    = 1'b1;
      dir   = 1'b0;
      clr   = 1'b0;
      #3;
      check("reset.seg", seg, 28'd0);
      check("reset.wrap", 28'(wrap), 28'd0);

      // tick already high at release must not count
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("release.seg", seg, 28'h6200000);
      check("release.wrap", 28'(wrap), 28'd0);
      tick = 1'b0;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 16; i++)
         do_step($sformatf("vec%0d", i), tbl[i].dir, tbl[i].seg,
                 tbl[i].wrap);

      // held tick: one step only (pos 10 -> 11)
      @(negedge clk);
      tick = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (wrap) wraps++;
      end
      tick = 1'b0;
      @(negedge clk);
      check("hold.seg", seg, 28'h7000000);
      check("hold.wraps", 28'(wraps), 28'd0);

      // edge while disabled is dropped
      en = 1'b0;
      @(negedge clk);
      tick = 1'b1;
      repeat (3) begin
         @(negedge clk);
         if (wrap) wraps++;
      end
      tick = 1'b0;
      en   = 1'b1;
      repeat (3) @(negedge clk);
      check("noen.seg", seg, 28'h7000000);
      check("noen.wraps", 28'(wraps), 28'd0);

      do_step("to0", 1'b0, 28'h6200000, 1'b1);
      for (int i = 0; i < 7; i++)
         do_step($sformatf("to7_%0d", i), tbl[i].dir, tbl[i].seg,
                 tbl[i].wrap);

      // clear wins over a simultaneous step
      @(negedge clk);
      tick = 1'b1;
      clr  = 1'b1;
      @(negedge clk);
      check("clr.wrap", 28'(wrap), 28'd0);
      tick = 1'b0;
      clr  = 1'b0;
      @(negedge clk);
      check("clr.seg", seg, 28'h6200000);
      repeat (2) @(negedge clk);
      do_step("clr.next", 1'b0, 28'h4204000, 1'b0);
      do_step("ccw1to0", 1'b1, 28'h0204080, 1'b0);

      // async reset while wrap_o is high
      @(negedge clk);
      tick = 1'b1;
      dir  = 1'b1;
      @(posedge clk);
      #2;
      check("prerst.wrap", 28'(wrap), 28'd1);
      rst_n = 1'b0;
      #1;
      check("midrst.seg", seg, 28'd0);
      check("midrst.wrap", 28'(wrap), 28'd0);
      tick = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("rerun.seg", seg, 28'h6200000);
      do_step("rerun.step", 1'b0, 28'h4204000, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
